// File: rtl/nx_stat_counter_pkg.sv
// Shared stat counter types: controller op codes plus the event collector's slot and CSR types.
package nx_stat_counter;

  typedef enum logic [1:0] {
    COUNT      = 2'd0,
    READ       = 2'd1,
    READ_CLEAR = 2'd2,
    WRITE      = 2'd3
  } counter_op_e;

  localparam int unsigned STAT_N_ENTRIES = 1024;
  localparam int unsigned STAT_ADDR_W    = $clog2(STAT_N_ENTRIES);
  localparam int unsigned STAT_TOTAL_W   = 102;
  localparam int unsigned STAT_INC_W     = 15;
  localparam int unsigned STAT_F1_W      = 14;
  localparam int unsigned STAT_F1_LSB    = 32;

  localparam int unsigned STAT_ID_EVENT = 0;
  localparam int unsigned STAT_ID_CSR   = 1;

  typedef struct packed {
    logic [STAT_ADDR_W-1:0] addr;
    logic [STAT_INC_W-1:0]  inc;
  } stat_slot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } csr_state_e;

  // Per-field saturating add: bit 0 is a 1-bit field, bits [14:1] a 14-bit field.
  function automatic logic [STAT_INC_W-1:0] stat_inc_merge(input logic [STAT_INC_W-1:0] a,
                                                           input logic [STAT_INC_W-1:0] b);
    logic [STAT_F1_W:0] f1_sum;
    logic               f0;
    f0     = a[0] | b[0];
    f1_sum = {1'b0, a[STAT_INC_W-1:1]} + {1'b0, b[STAT_INC_W-1:1]};
    return {f1_sum[STAT_F1_W] ? {STAT_F1_W{1'b1}} : f1_sum[STAT_F1_W-1:0], f0};
  endfunction

endpackage

// File: rtl/nx_stat_event_collector_rr_arb.sv
// N-way round-robin arbiter; search starts at the pointer, which moves past the grant on advance.
module nx_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic          o_valid,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] r_ptr;
  int unsigned   w_idx;

  always_comb begin
    o_valid     = 1'b0;
    o_grant_idx = r_ptr;
    w_idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = (r_ptr + k) % N;
      if (!o_valid && i_req[IW'(w_idx)]) begin
        o_valid     = 1'b1;
        o_grant_idx = IW'(w_idx);
      end
    end
    o_grant = o_valid ? (N'(1) << o_grant_idx) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && o_valid) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/nx_stat_event_collector.sv
// Event collector in front of the stat counter controller: per-client slots, RR arbitration, CSR mux.
// Optional same-address merging of held events: define NX_STAT_EVENT_COALESCE_EN.
module nx_stat_event_collector
  import nx_stat_counter::*;
#(
  parameter int unsigned N_CLIENTS   = 4,
  parameter int unsigned N_ENTRIES   = STAT_N_ENTRIES,
  parameter int unsigned TOTAL_WIDTH = STAT_TOTAL_W,
  parameter int unsigned INC_WIDTH   = STAT_INC_W,
  parameter int unsigned ID_WIDTH    = 1,
  localparam int unsigned AW = $clog2(N_ENTRIES),
  localparam int unsigned CW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [N_CLIENTS-1:0]           i_ev_valid,
  output logic [N_CLIENTS-1:0]           o_ev_ready,
  input  logic [N_CLIENTS*AW-1:0]        i_ev_addr,
  input  logic [N_CLIENTS*INC_WIDTH-1:0] i_ev_inc,
  input  logic                           i_csr_valid,
  output logic                           o_csr_ready,
  input  counter_op_e                    i_csr_op,
  input  logic [AW-1:0]                  i_csr_addr,
  input  logic [TOTAL_WIDTH-1:0]         i_csr_wdata,
  output logic                           o_csr_rsp_valid,
  input  logic                           i_csr_rsp_ready,
  output logic [TOTAL_WIDTH-1:0]         o_csr_rsp_data,
  output logic                           o_req_valid,
  input  logic                           i_req_ready,
  output logic [AW-1:0]                  o_req_addr,
  output logic [TOTAL_WIDTH-1:0]         o_req_data,
  output logic [ID_WIDTH-1:0]            o_req_id,
  output counter_op_e                    o_req_op,
  input  logic                           i_rsp_valid,
  output logic                           o_rsp_ready,
  input  logic [TOTAL_WIDTH-1:0]         i_rsp_data,
  input  logic [ID_WIDTH-1:0]            i_rsp_id
);

  localparam logic SLOT_EMPTY = 1'b0;
  localparam logic SLOT_HELD  = 1'b1;

  logic [N_CLIENTS-1:0] r_slot_state;
  stat_slot_t           r_slot [N_CLIENTS];
  stat_slot_t           w_ev_slot [N_CLIENTS];
  logic [N_CLIENTS-1:0] w_slot_held;
  logic [N_CLIENTS-1:0] w_ev_accept;
  logic [N_CLIENTS-1:0] w_take_vec;

  logic                 r_req_valid;
  logic [AW-1:0]        r_req_addr;
  logic [TOTAL_WIDTH-1:0] r_req_data;
  logic [ID_WIDTH-1:0]  r_req_id;
  counter_op_e          r_req_op;

  csr_state_e           r_csr_state;
  counter_op_e          r_csr_op;
  logic [AW-1:0]        r_csr_addr;
  logic [TOTAL_WIDTH-1:0] r_csr_wdata;
  logic [TOTAL_WIDTH-1:0] r_csr_rsp_data;

  logic                 w_arb_valid;
  logic [N_CLIENTS-1:0] w_grant;
  logic [CW-1:0]        w_grant_idx;
  logic                 w_load;
  logic                 w_csr_in_stage;
  logic                 w_csr_pending;
  logic                 w_take;
  stat_slot_t           w_sel;
  logic [TOTAL_WIDTH-1:0] w_ev_data;

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_ev_slot[i].addr = i_ev_addr[i*AW +: AW];
      w_ev_slot[i].inc  = i_ev_inc[i*INC_WIDTH +: INC_WIDTH];
      w_slot_held[i]    = (r_slot_state[i] == SLOT_HELD);
    end
  end

  nx_rr_arb #(
    .N (N_CLIENTS)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (w_slot_held),
    .i_advance   (w_take),
    .o_valid     (w_arb_valid),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // The output stage refills whenever it is empty or handing off this cycle.
  assign w_load         = !r_req_valid || i_req_ready;
  assign w_csr_in_stage = r_req_valid && (r_req_id == ID_WIDTH'(STAT_ID_CSR));
  assign w_csr_pending  = (r_csr_state == ISSUE) && !w_csr_in_stage;
  assign w_take         = w_load && !w_csr_pending && w_arb_valid;
  assign w_sel          = r_slot[w_grant_idx];

  always_comb begin
    w_ev_data = '0;
    w_ev_data[0] = w_sel.inc[0];
    w_ev_data[STAT_F1_LSB +: STAT_F1_W] = w_sel.inc[INC_WIDTH-1:1];
  end

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_take_vec[i] = w_take && w_grant[i];
`ifdef NX_STAT_EVENT_COALESCE_EN
      o_ev_ready[i] = !w_slot_held[i] || w_take_vec[i] ||
                      (r_slot[i].addr == w_ev_slot[i].addr);
`else
      o_ev_ready[i] = !w_slot_held[i] || w_take_vec[i];
`endif
      w_ev_accept[i] = i_ev_valid[i] && o_ev_ready[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_state <= {N_CLIENTS{SLOT_EMPTY}};
      for (int i = 0; i < N_CLIENTS; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (w_ev_accept[i]) begin
          r_slot_state[i] <= SLOT_HELD;
`ifdef NX_STAT_EVENT_COALESCE_EN
          // A slot leaving this cycle takes the new event verbatim; otherwise fold it in.
          if (w_slot_held[i] && !w_take_vec[i]) begin
            r_slot[i].inc <= stat_inc_merge(r_slot[i].inc, w_ev_slot[i].inc);
          end else begin
            r_slot[i] <= w_ev_slot[i];
          end
`else
          r_slot[i] <= w_ev_slot[i];
`endif
        end else if (w_take_vec[i]) begin
          r_slot_state[i] <= SLOT_EMPTY;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_id    <= '0;
      r_req_op    <= COUNT;
    end else if (w_load) begin
      if (w_csr_pending) begin
        r_req_valid <= 1'b1;
        r_req_addr  <= r_csr_addr;
        r_req_data  <= r_csr_wdata;
        r_req_id    <= ID_WIDTH'(STAT_ID_CSR);
        r_req_op    <= r_csr_op;
      end else if (w_arb_valid) begin
        r_req_valid <= 1'b1;
        r_req_addr  <= w_sel.addr;
        r_req_data  <= w_ev_data;
        r_req_id    <= ID_WIDTH'(STAT_ID_EVENT);
        r_req_op    <= COUNT;
      end else begin
        r_req_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csr_state    <= IDLE;
      r_csr_op       <= READ;
      r_csr_addr     <= '0;
      r_csr_wdata    <= '0;
      r_csr_rsp_data <= '0;
    end else begin
      unique case (r_csr_state)
        IDLE: begin
          if (i_csr_valid) begin
            r_csr_state <= ISSUE;
            r_csr_op    <= (i_csr_op == COUNT) ? READ : i_csr_op;
            r_csr_addr  <= i_csr_addr;
            r_csr_wdata <= i_csr_wdata;
          end
        end
        ISSUE: if (w_csr_in_stage && i_req_ready) r_csr_state <= WAIT;
        WAIT: begin
          if (i_rsp_valid && (i_rsp_id == ID_WIDTH'(STAT_ID_CSR))) begin
            r_csr_state    <= RESP;
            r_csr_rsp_data <= i_rsp_data;
          end
        end
        RESP: if (i_csr_rsp_ready) r_csr_state <= IDLE;
        default: r_csr_state <= IDLE;
      endcase
    end
  end

  assign o_csr_ready     = (r_csr_state == IDLE);
  assign o_csr_rsp_valid = (r_csr_state == RESP);
  assign o_csr_rsp_data  = r_csr_rsp_data;
  assign o_rsp_ready     = (i_rsp_id == ID_WIDTH'(STAT_ID_EVENT)) || (r_csr_state == WAIT);

  assign o_req_valid = r_req_valid;
  assign o_req_addr  = r_req_addr;
  assign o_req_data  = r_req_data;
  assign o_req_id    = r_req_id;
  assign o_req_op    = r_req_op;

  a_csr_op_legal : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_csr_valid && o_csr_ready && (i_csr_op == COUNT)))
    else $error("csr_op COUNT is not a legal CSR access");

endmodule

// File: doc/nx_stat_event_collector.md
Name: nx_stat_event_collector

Overview:
Sits directly upstream of the stat counter controller and drives its req_*/rsp_* interface.
- Collects counter-increment events from N_CLIENTS independent sources, one holding slot per client with optional same-address merging.
- Arbitrates the held slots round-robin into COUNT requests.
- Multiplexes a single CSR access port (READ/READ_CLEAR/WRITE) onto the same request stream and routes CSR responses back.
- Event responses are sunk internally.

Parameters:
N_CLIENTS, 4, number of event sources
N_ENTRIES, 1024, counter table depth; address width is log2(N_ENTRIES)
TOTAL_WIDTH, 102, packed entry width, equal to the controller's entry width
INC_WIDTH, 15, packed increment width; field0 = bits [0], field1 = bits [14:1], matching controller add widths {14,1}
ID_WIDTH, 1, controller request id width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ev_valid  in  N_CLIENTS  per-client event valid
ev_ready  out  N_CLIENTS  per-client event accept
ev_addr  in  N_CLIENTS*log2(N_ENTRIES)  per-client counter address, packed
ev_inc  in  N_CLIENTS*INC_WIDTH  per-client packed increments
csr_valid  in  1  CSR request valid
csr_ready  out  1  CSR request accept
csr_op  in  counter_op_e  READ, READ_CLEAR or WRITE; COUNT is illegal
csr_addr  in  log2(N_ENTRIES)  CSR counter address
csr_wdata  in  TOTAL_WIDTH  CSR write data
csr_rsp_valid  out  1  CSR response valid
csr_rsp_ready  in  1  CSR response accept
csr_rsp_data  out  TOTAL_WIDTH  CSR response data
req_valid/req_ready/req_addr/req_data/req_id/req_op  out/in/out/out/out/out  1/1/log2(N_ENTRIES)/TOTAL_WIDTH/ID_WIDTH/counter_op_e  request to controller
rsp_valid/rsp_ready/rsp_data/rsp_id  in/out/in/in  1/1/TOTAL_WIDTH/ID_WIDTH  response from controller

Behaviour:
- Reset values:
  - ev_ready = all 1s; csr_ready = 1.
  - req_valid = 0; csr_rsp_valid = 0; rsp_ready = 1.
  - All slots EMPTY; round-robin pointer = 0; CSR FSM = IDLE.
- Client slot FSM, EMPTY/HELD; each slot holds addr + inc.
  - EMPTY + ev_valid -> HELD on the same edge; ev_ready = 1 while EMPTY.
  - HELD + granted + req_ready -> EMPTY, unless a new event is accepted in the same cycle, in which case it stays HELD with the new event's contents.
  - The new event is never merged into the outgoing request.
- Request mux:
  - Registered output stage; req_* stays stable while req_valid && !req_ready.
  - CSR has strict priority over events when the CSR FSM is in ISSUE.
  - Otherwise the round-robin grant is taken among HELD slots, starting at the pointer; the pointer advances to grant+1 (mod N_CLIENTS) only on a req_ready handshake.
  - Event request: op = COUNT, id = 0, data = zero-extended inc placed at controller field LSBs (field0 -> bit 0, field1 -> bits 45:32).
  - Latency: event accept to req_valid = 1 cycle minimum.
- CSR FSM:
  - IDLE: csr_ready = 1; a handshake latches op/addr/wdata and moves to ISSUE.
  - ISSUE: req_valid with id = 1, req_data = wdata; on req_ready moves to WAIT.
  - WAIT: waits for rsp_valid with rsp_id == 1, moves to RESP, and captures rsp_data.
  - RESP: csr_rsp_valid = 1; on csr_rsp_ready moves to IDLE.
  - csr_ready = 0 outside IDLE, so exactly one CSR access is outstanding.
  - csr_op == COUNT: asserted illegal (simulation ERROR); treated as READ.
- Response routing:
  - rsp_id == 0: sunk, rsp_ready = 1.
  - rsp_id == 1: rsp_ready = 1 only in WAIT; response captured.
- Simultaneous events: CSR ISSUE + all slots HELD -> CSR first, then events resume at the unchanged round-robin pointer.
- Reset mid-operation: all state discarded; the controller is reset together with this block.

Optional Feature:
- NX_STAT_EVENT_COALESCE_EN defined:
  - A HELD, not-currently-handshaking slot also accepts ev_valid when ev_addr equals the held addr.
  - Each field is added independently and saturates at all-ones of its field width (1 bit, 14 bits).
  - ev_ready = EMPTY || addr-match || (granted && req_ready).
- Undefined:
  - ev_ready = EMPTY || (granted && req_ready); no adders are instantiated.

Decomposition:
- Package nx_stat_counter (existing) supplies counter_op_e.
- Add to it: localparams STAT_ID_EVENT = 0 and STAT_ID_CSR = 1; typedef stat_slot_t {addr, inc}; csr_state_e {IDLE, ISSUE, WAIT, RESP}.
- One sub-module: nx_rr_arb (N-way round-robin, grant + advance-on-accept).

Test Plan:
- Single event client 2, addr 5, inc field1=3/field0=1 -> req COUNT addr 5, data bit0=1, bits[45:32]=3, id 0, one cycle later.
- All 4 clients HELD, req_ready=1 -> grants in order 0,1,2,3; with req_ready stalled 3 cycles, req_* stays stable.
- CSR READ addr 7 while events HELD -> CSR request issued first with id 1; rsp_data 0x1234 -> csr_rsp_data 0x1234; csr_ready low until csr_rsp_ready.
- Coalesce on: client 0 HELD addr 9 field1=0x3FFE, new event addr 9 field1=5 -> merged field1 = 0x3FFF (saturated), ev_ready=1; different addr -> ev_ready=0.
- Coalesce off: same stimulus -> ev_ready=0 until issue; two separate COUNT requests.
- Assert rst_n low during WAIT with csr_rsp pending -> all outputs return to reset values immediately; no csr_rsp_valid after release.
